// File: rtl/tb_tcdm_memory_model_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tcdm_memory_model_pkg                                                 |
// | Shared constants and helpers for the multi-port TCDM memory model.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package tb_tcdm_memory_model_pkg;

    localparam logic [15:0] C_LFSR_TAPS = 16'hB400;

    // Per-port seed: the all-zero state would lock a Galois LFSR, so it maps to 1.
    function automatic logic [15:0] remap_seed(input logic [15:0] seed, input int unsigned port);
        logic [15:0] s;
        s = seed ^ port[15:0];
        return (s == 16'h0) ? 16'h1 : s;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tb_tcdm_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tcdm_lfsr                                                             |
// | 16-bit Galois LFSR, free-running outside reset, reseeded by rst_i.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tcdm_lfsr
    import tb_tcdm_memory_model_pkg::*;
#(
    parameter logic [15:0] SEED = 16'h0001
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] state_o
);

    logic [15:0] r_state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= SEED;
        end else begin
            r_state <= (r_state >> 1) ^ (r_state[0] ? C_LFSR_TAPS : 16'h0000);
        end
    end

    assign state_o = r_state;

endmodule
`default_nettype wire

// File: rtl/tb_tcdm_memory_model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tcdm_memory_model                                                     |
// | Multi-port TCDM slave model: byte enables, fixed latency, LFSR stalls.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tcdm_memory_model
    import tb_tcdm_memory_model_pkg::*;
#(
    parameter int unsigned    NB_PORTS     = 4,
    parameter int unsigned    DW           = 32,
    parameter int unsigned    AW           = 32,
    parameter int unsigned    MEM_WORDS    = 1024,
    parameter logic [AW-1:0]  BASE_ADDR    = '0,
    parameter int unsigned    LATENCY      = 1,
    parameter logic [15:0]    STALL_THR    = 16'd0,
    parameter logic [15:0]    LFSR_SEED    = 16'hACE1,
    parameter bit             WRITE_RVALID = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     stall_en_i,
    input  logic [NB_PORTS-1:0]      tcdm_req_i,
    output logic [NB_PORTS-1:0]      tcdm_gnt_o,
    input  logic [NB_PORTS*AW-1:0]   tcdm_add_i,
    input  logic [NB_PORTS-1:0]      tcdm_wen_i,
    input  logic [NB_PORTS*DW/8-1:0] tcdm_be_i,
    input  logic [NB_PORTS*DW-1:0]   tcdm_data_i,
    output logic [NB_PORTS*DW-1:0]   tcdm_r_data_o,
    output logic [NB_PORTS-1:0]      tcdm_r_valid_o,
    output logic [NB_PORTS-1:0]      err_o,
    output logic [NB_PORTS*32-1:0]   rd_cnt_o,
    output logic [NB_PORTS*32-1:0]   wr_cnt_o,
    output logic [NB_PORTS*32-1:0]   stall_cnt_o
);

    localparam int unsigned   C_NBYTES    = DW / 8;
    localparam int unsigned   C_OFFS      = $clog2(C_NBYTES);
    localparam int unsigned   C_IW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [AW-1:0] C_MEM_WORDS = AW'(MEM_WORDS);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0]       r_mem    [MEM_WORDS];
    logic [C_IW-1:0]     w_idx    [NB_PORTS];
    logic [DW-1:0]       w_pre    [NB_PORTS];
    logic [DW-1:0]       w_post   [NB_PORTS];
    logic [NB_PORTS-1:0] w_gnt;
    logic [NB_PORTS-1:0] w_oor;
    logic [NB_PORTS-1:0] w_wr_acc;

    // Every port sees the word as it will be after all same-cycle writes, so
    // colliding writers agree and a write response carries the merged result.
    always_comb begin
        logic [DW-1:0] w_word;
        for (int p = 0; p < NB_PORTS; p++) begin
            w_word = w_pre[p];
            for (int q = NB_PORTS - 1; q >= 0; q--) begin
                if (w_wr_acc[q] && !w_oor[p] && (w_idx[q] == w_idx[p])) begin
                    for (int b = 0; b < C_NBYTES; b++) begin
                        if (tcdm_be_i[q*C_NBYTES + b]) begin
                            w_word[b*8 +: 8] = tcdm_data_i[q*DW + b*8 +: 8];
                        end
                    end
                end
            end
            w_post[p] = w_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NB_PORTS; p++) begin
                if (w_wr_acc[p]) begin
                    r_mem[w_idx[p]] <= w_post[p];
                end
            end
        end
    end

    assign tcdm_gnt_o = w_gnt;

    for (genvar p = 0; p < NB_PORTS; p++) begin : g_port
        logic [AW-1:0] w_add;
        logic [AW-1:0] w_off;
        logic [15:0]   w_lfsr;
        logic          w_rsp;
        rsp_t          r_pipe [LATENCY];
        logic [31:0]   r_rd_cnt;
        logic [31:0]   r_wr_cnt;
        logic [31:0]   r_stall_cnt;
        logic          r_err;

        tb_tcdm_lfsr #(
            .SEED (remap_seed(LFSR_SEED, p))
        ) u_lfsr (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .state_o (w_lfsr)
        );

        assign w_add       = tcdm_add_i[p*AW +: AW];
        assign w_off       = (w_add - BASE_ADDR) >> C_OFFS;
        assign w_oor[p]    = (w_add < BASE_ADDR) || (w_off >= C_MEM_WORDS);
        assign w_idx[p]    = w_off[C_IW-1:0];
        assign w_pre[p]    = w_oor[p] ? '0 : r_mem[w_idx[p]];
        assign w_gnt[p]    = tcdm_req_i[p] & enable_i & ~(stall_en_i & (w_lfsr < STALL_THR));
        assign w_wr_acc[p] = w_gnt[p] & ~tcdm_wen_i[p] & ~w_oor[p];
        assign w_rsp       = w_gnt[p] & (tcdm_wen_i[p] | WRITE_RVALID);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < LATENCY; i++) begin
                    r_pipe[i] <= '0;
                end
            end else begin
                r_pipe[0].valid <= w_rsp;
                r_pipe[0].data  <= w_rsp ? (tcdm_wen_i[p] ? w_pre[p] : w_post[p]) : '0;
                for (int i = 1; i < LATENCY; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_rd_cnt    <= '0;
                r_wr_cnt    <= '0;
                r_stall_cnt <= '0;
                r_err       <= 1'b0;
            end else begin
                if (w_gnt[p] && tcdm_wen_i[p]) begin
                    r_rd_cnt <= sat_inc(r_rd_cnt);
                end
                if (w_gnt[p] && !tcdm_wen_i[p]) begin
                    r_wr_cnt <= sat_inc(r_wr_cnt);
                end
                if (tcdm_req_i[p] && !w_gnt[p]) begin
                    r_stall_cnt <= sat_inc(r_stall_cnt);
                end
                if (w_gnt[p] && w_oor[p]) begin
                    r_err <= 1'b1;
                end
            end
        end

        assign tcdm_r_valid_o[p]          = r_pipe[LATENCY-1].valid;
        assign tcdm_r_data_o[p*DW +: DW]  = r_pipe[LATENCY-1].valid ? r_pipe[LATENCY-1].data : '0;
        assign err_o[p]                   = r_err;
        assign rd_cnt_o[p*32 +: 32]       = r_rd_cnt;
        assign wr_cnt_o[p*32 +: 32]       = r_wr_cnt;
        assign stall_cnt_o[p*32 +: 32]    = r_stall_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_tb_tcdm_memory_model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tb_tcdm_memory_model                                                  |
// | Randomised and directed bench for the TCDM memory model.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_tb_tcdm_memory_model;

    localparam int          NP   = 4;
    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam int          NB   = DW / 8;
    localparam int          MW   = 64;
    localparam int          LAT  = 3;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [15:0] THR  = 16'd32768;
    localparam logic [15:0] SEED = 16'hACE1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable = 1'b1;
    logic             stall_en = 1'b0;
    logic [NP-1:0]    req = '0;
    logic [NP-1:0]    gnt;
    logic [NP*AW-1:0] add = '0;
    logic [NP-1:0]    wen = '1;
    logic [NP*NB-1:0] be = '0;
    logic [NP*DW-1:0] wdata = '0;
    logic [NP*DW-1:0] rdata;
    logic [NP-1:0]    rvalid;
    logic [NP-1:0]    err;
    logic [NP*32-1:0] rd_cnt;
    logic [NP*32-1:0] wr_cnt;
    logic [NP*32-1:0] stall_cnt;

    always #5 clk = ~clk;

    tb_tcdm_memory_model #(
        .NB_PORTS     (NP),
        .DW           (DW),
        .AW           (AW),
        .MEM_WORDS    (MW),
        .BASE_ADDR    (BASE),
        .LATENCY      (LAT),
        .STALL_THR    (THR),
        .LFSR_SEED    (SEED),
        .WRITE_RVALID (1'b1)
    ) u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .stall_en_i     (stall_en),
        .tcdm_req_i     (req),
        .tcdm_gnt_o     (gnt),
        .tcdm_add_i     (add),
        .tcdm_wen_i     (wen),
        .tcdm_be_i      (be),
        .tcdm_data_i    (wdata),
        .tcdm_r_data_o  (rdata),
        .tcdm_r_valid_o (rvalid),
        .err_o          (err),
        .rd_cnt_o       (rd_cnt),
        .wr_cnt_o       (wr_cnt),
        .stall_cnt_o    (stall_cnt)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: flat word array, per-port queues of (due cycle, data).
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic [DW-1:0] m_mem   [MW];
    logic [15:0]   m_lfsr  [NP];
    int unsigned   m_rd    [NP];
    int unsigned   m_wr    [NP];
    int unsigned   m_st    [NP];
    logic [NP-1:0] m_err;
    exp_t          m_q     [NP][$];
    logic [DW-1:0] last_data [NP];
    int            last_cyc  [NP];

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < MW);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic set_port(input int p, input bit r, input bit is_read,
                            input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        req[p]             = r;
        wen[p]             = is_read;
        add[p*AW +: AW]    = a;
        be[p*NB +: NB]     = b;
        wdata[p*DW +: DW]  = d;
    endtask

    task automatic clear_ports();
        req = '0; wen = '1; add = '0; be = '0; wdata = '0;
    endtask

    // One clock: check grants, advance the model, then check the responses.
    task automatic tick();
        logic [NP-1:0] exp_gnt;
        logic [DW-1:0] nmem [MW];
        logic [31:0]   a;
        logic [15:0]   s;
        #1;
        for (int p = 0; p < NP; p++) begin
            exp_gnt[p] = req[p] && enable && !(stall_en && (m_lfsr[p] < THR));
        end
        total++;
        if (gnt !== exp_gnt) begin
            bad++;
            $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_gnt);
        end
        if (rst) begin
            for (int i = 0; i < MW; i++) m_mem[i] = '0;
            for (int p = 0; p < NP; p++) begin
                m_q[p].delete();
                m_rd[p] = 0; m_wr[p] = 0; m_st[p] = 0;
                s = SEED ^ 16'(p);
                m_lfsr[p] = (s == 16'h0) ? 16'h1 : s;
            end
            m_err = '0;
        end else begin
            nmem = m_mem;
            for (int p = NP - 1; p >= 0; p--) begin
                a = add[p*AW +: AW];
                if (exp_gnt[p] && !wen[p] && in_range(a)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (be[p*NB + b]) nmem[word_of(a)][b*8 +: 8] = wdata[p*DW + b*8 +: 8];
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                a = add[p*AW +: AW];
                if (req[p] && !exp_gnt[p]) m_st[p]++;
                if (exp_gnt[p]) begin
                    if (!in_range(a)) m_err[p] = 1'b1;
                    if (wen[p]) begin
                        m_rd[p]++;
                        m_q[p].push_back('{cyc + LAT, in_range(a) ? m_mem[word_of(a)] : '0});
                    end else begin
                        m_wr[p]++;
                        m_q[p].push_back('{cyc + LAT, in_range(a) ? nmem[word_of(a)] : '0});
                    end
                end
                m_lfsr[p] = (m_lfsr[p] >> 1) ^ (m_lfsr[p][0] ? 16'hB400 : 16'h0000);
            end
            m_mem = nmem;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < NP; p++) begin
            logic          ev;
            logic [DW-1:0] ed;
            ev = (m_q[p].size() > 0) && (m_q[p][0].due == cyc);
            ed = ev ? m_q[p][0].data : '0;
            if (ev) begin
                void'(m_q[p].pop_front());
                last_data[p] = ed;
                last_cyc[p]  = cyc;
            end
            total++;
            if (rvalid[p] !== ev || rdata[p*DW +: DW] !== ed) begin
                bad++;
                $display("FAIL rsp port=%0d cyc=%0d got v=%b d=%h exp v=%b d=%h",
                         p, cyc, rvalid[p], rdata[p*DW +: DW], ev, ed);
            end
        end
    endtask

    task automatic drain();
        clear_ports();
        repeat (LAT + 2) tick();
    endtask

    task automatic do_reset();
        clear_ports();
        stall_en = 1'b0;
        enable   = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (rvalid !== '0 || rdata !== '0 || err !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b err=%b d=%h exp all zero", rvalid, err, rdata);
        end
        total++;
        if (rd_cnt !== '0 || wr_cnt !== '0 || stall_cnt !== '0) begin
            bad++;
            $display("FAIL reset_counters got rd=%h wr=%h st=%h exp 0", rd_cnt, wr_cnt, stall_cnt);
        end
    endtask

    task automatic test_read_after_write();
        int g;
        do_reset();
        set_port(0, 1, 0, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
        tick();
        clear_ports();
        set_port(0, 1, 1, BASE + 32'h10, 4'h0, 32'h0);
        g = cyc;
        tick();
        clear_ports();
        repeat (LAT + 2) tick();
        total++;
        if (last_cyc[0] - g !== LAT || last_data[0] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL raw got lat=%0d d=%h exp lat=%0d d=deadbeef", last_cyc[0] - g, last_data[0], LAT);
        end
        total++;
        if (rd_cnt[31:0] !== 32'd1 || wr_cnt[31:0] !== 32'd1) begin
            bad++;
            $display("FAIL raw_counts got rd=%0d wr=%0d exp 1 1", rd_cnt[31:0], wr_cnt[31:0]);
        end
    endtask

    task automatic test_byte_enables();
        do_reset();
        set_port(1, 1, 0, BASE + 32'h8, 4'hF, 32'h0);
        tick();
        set_port(1, 1, 0, BASE + 32'h8, 4'h3, 32'hFFFF_FFFF);
        tick();
        set_port(1, 1, 1, BASE + 32'h8, 4'h0, 32'h0);
        tick();
        drain();
        total++;
        if (last_data[1] !== 32'h0000_FFFF) begin
            bad++;
            $display("FAIL byte_en got=%h exp=0000ffff", last_data[1]);
        end
    endtask

    task automatic test_collision();
        do_reset();
        set_port(0, 1, 0, BASE + 32'h14, 4'hF, 32'h1111_1111);
        set_port(1, 1, 1, BASE + 32'h14, 4'h0, 32'h0);
        set_port(2, 1, 0, BASE + 32'h14, 4'hF, 32'h2222_2222);
        tick();
        clear_ports();
        set_port(3, 1, 1, BASE + 32'h14, 4'h0, 32'h0);
        tick();
        drain();
        total++;
        if (last_data[3] !== 32'h1111_1111 || last_data[2] !== 32'h1111_1111) begin
            bad++;
            $display("FAIL collision got rd=%h wrsp=%h exp 11111111", last_data[3], last_data[2]);
        end
        total++;
        if (last_data[1] !== 32'h0) begin
            bad++;
            $display("FAIL rw_collision got=%h exp=00000000", last_data[1]);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        set_port(0, 1, 0, BASE, 4'hF, 32'hA5A5_A5A5);
        tick();
        clear_ports();
        set_port(1, 1, 1, 32'h0000_0FFC, 4'h0, 32'h0);
        set_port(2, 1, 0, BASE + 32'h100, 4'hF, 32'hFFFF_FFFF);
        tick();
        drain();
        total++;
        if (err !== 4'b0110 || last_data[1] !== 32'h0) begin
            bad++;
            $display("FAIL oor got err=%b d=%h exp err=0110 d=0", err, last_data[1]);
        end
        set_port(1, 1, 1, BASE + 32'hFC, 4'h0, 32'h0);
        set_port(2, 1, 1, BASE, 4'h0, 32'h0);
        tick();
        drain();
        total++;
        if (err !== 4'b0110 || last_data[1] !== 32'h0 || last_data[2] !== 32'hA5A5_A5A5) begin
            bad++;
            $display("FAIL oor_sticky got err=%b top=%h w0=%h exp 0110 0 a5a5a5a5",
                     err, last_data[1], last_data[2]);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            stall_en = (c >= 200);
            enable   = ($urandom_range(0, 9) != 0);
            for (int p = 0; p < NP; p++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
                else if (r == 1) a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 3));
                else             a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
                set_port(p, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, a,
                         4'($urandom_range(0, 15)), $urandom);
            end
            tick();
        end
        stall_en = 1'b0;
        enable   = 1'b1;
        drain();
        for (int p = 0; p < NP; p++) begin
            total++;
            if (rd_cnt[p*32 +: 32] !== m_rd[p] || wr_cnt[p*32 +: 32] !== m_wr[p] ||
                stall_cnt[p*32 +: 32] !== m_st[p] || err[p] !== m_err[p]) begin
                bad++;
                $display("FAIL rand_counts port=%0d got rd=%0d wr=%0d st=%0d e=%b exp %0d %0d %0d %b",
                         p, rd_cnt[p*32 +: 32], wr_cnt[p*32 +: 32], stall_cnt[p*32 +: 32], err[p],
                         m_rd[p], m_wr[p], m_st[p], m_err[p]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] st [2];
        logic [31:0] rd;
        for (int run = 0; run < 2; run++) begin
            do_reset();
            stall_en = 1'b1;
            set_port(0, 1, 1, BASE, 4'h0, 32'h0);
            repeat (1000) tick();
            stall_en = 1'b0;
            drain();
            st[run] = stall_cnt[31:0];
            rd      = rd_cnt[31:0];
            total++;
            if (st[run] + rd !== 32'd1000 || st[run] < 32'd400 || st[run] > 32'd600 || st[run] !== m_st[0]) begin
                bad++;
                $display("FAIL stall run=%0d got st=%0d rd=%0d exp sum 1000 st=%0d", run, st[run], rd, m_st[0]);
            end
        end
        total++;
        if (st[0] !== st[1]) begin
            bad++;
            $display("FAIL stall_repeat got %0d exp %0d", st[1], st[0]);
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        do_reset();
        set_port(0, 1, 0, BASE, 4'hF, 32'h1234_5678);
        tick();
        set_port(0, 1, 1, BASE, 4'h0, 32'h0);
        set_port(3, 1, 0, BASE + 32'h40, 4'h0, 32'h0);
        tick();
        clear_ports();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 0;
        repeat (LAT + 2) begin
            tick();
            if (rvalid !== '0) seen++;
        end
        total++;
        if (seen !== 0 || err !== '0 || rd_cnt !== '0 || wr_cnt !== '0 || stall_cnt !== '0) begin
            bad++;
            $display("FAIL midflight got pulses=%0d err=%b rd=%h wr=%h exp all zero", seen, err, rd_cnt, wr_cnt);
        end
        set_port(0, 1, 1, BASE, 4'h0, 32'h0);
        tick();
        drain();
        total++;
        if (last_data[0] !== 32'h0) begin
            bad++;
            $display("FAIL midflight_mem got=%h exp=00000000", last_data[0]);
        end
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            last_data[p] = '0;
            last_cyc[p]  = 0;
            m_lfsr[p]    = 16'h1;
        end
        test_reset();
        test_read_after_write();
        test_byte_enables();
        test_collision();
        test_out_of_range();
        test_random();
        test_stall();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
